// File: rtl/conv_input_loader_pkg.sv
// Shared defaults and state encoding for the convolution input loader.
package conv_input_loader_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned ADDR_WIDTH_DEF = 5;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD_X    = 3'd1,
      ST_LOAD_Y    = 3'd2,
      ST_START     = 3'd3,
      ST_WAIT_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/conv_input_loader_if.sv
// Valid/ready sample stream feeding the loader.
interface conv_input_loader_if #(
   parameter int unsigned DATA_WIDTH = 8
) ();

   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/conv_input_mem.sv
// Sample store: one synchronous write port, one asynchronous read port, no reset.
module conv_input_mem #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_c
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/conv_input_loader.sv
// Loads X then Y samples from a stream, pulses start, and holds data stable until done.
module conv_input_loader
   import conv_input_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [ADDR_WIDTH-1:0] cfg_sizeX_i,
   input  logic [ADDR_WIDTH-1:0] cfg_sizeY_i,
   input  logic                  cfg_valid_i,
   conv_input_loader_if.slave    s_if,
   input  logic [ADDR_WIDTH-1:0] memXaddr_i,
   output logic [DATA_WIDTH-1:0] dataX_o,
   input  logic [ADDR_WIDTH-1:0] memYaddr_i,
   output logic [DATA_WIDTH-1:0] dataY_o,
   output logic [ADDR_WIDTH-1:0] sizeX_o,
   output logic [ADDR_WIDTH-1:0] sizeY_o,
   output logic                  start_o,
   input  logic                  done_i,
   output logic                  busy_o,
   output logic                  job_done_o,
   output logic                  err_o
);

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [ADDR_WIDTH-1:0] size_x_q;
   logic [ADDR_WIDTH-1:0] size_y_q;
   logic                  start_q;
   logic                  job_done_q;
   logic                  err_q;

   logic in_load_x;
   logic in_load_y;
   logic xfer;

   // Ready is a pure state decode so no input reaches it combinationally.
   assign in_load_x = (state_q == ST_LOAD_X);
   assign in_load_y = (state_q == ST_LOAD_Y);
   assign s_if.ready = in_load_x || in_load_y;
   assign xfer      = s_if.valid && s_if.ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         size_x_q   <= '0;
         size_y_q   <= '0;
         start_q    <= 1'b0;
         job_done_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         start_q    <= 1'b0;
         job_done_q <= 1'b0;
         err_q      <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (cfg_valid_i) begin
                  if ((cfg_sizeX_i != '0) && (cfg_sizeY_i != '0)) begin
                     size_x_q <= cfg_sizeX_i;
                     size_y_q <= cfg_sizeY_i;
                     cnt_q    <= '0;
                     state_q  <= ST_LOAD_X;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_LOAD_X: begin
               if (xfer) begin
                  if (cnt_q == size_x_q - ADDR_WIDTH'(1)) begin
                     cnt_q   <= '0;
                     state_q <= ST_LOAD_Y;
                  end else begin
                     cnt_q <= cnt_q + ADDR_WIDTH'(1);
                  end
               end
            end
            ST_LOAD_Y: begin
               if (xfer) begin
                  if (cnt_q == size_y_q - ADDR_WIDTH'(1)) begin
                     cnt_q   <= '0;
                     start_q <= 1'b1;
                     state_q <= ST_START;
                  end else begin
                     cnt_q <= cnt_q + ADDR_WIDTH'(1);
                  end
               end
            end
            ST_START: begin
               state_q <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (done_i) begin
                  job_done_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   conv_input_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem_x (
      .clk     (clk),
      .we_i    (in_load_x && s_if.valid),
      .waddr_i (cnt_q),
      .wdata_i (s_if.data),
      .raddr_i (memXaddr_i),
      .rdata_c (dataX_o)
   );

   conv_input_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem_y (
      .clk     (clk),
      .we_i    (in_load_y && s_if.valid),
      .waddr_i (cnt_q),
      .wdata_i (s_if.data),
      .raddr_i (memYaddr_i),
      .rdata_c (dataY_o)
   );

   assign sizeX_o    = size_x_q;
   assign sizeY_o    = size_y_q;
   assign start_o    = start_q;
   assign busy_o     = (state_q != ST_IDLE);
   assign job_done_o = job_done_q;
   assign err_o      = err_q;

endmodule

// File: doc/conv_input_loader.md
Name: conv_input_loader

Overview:
- Upstream stage of the convolution processor. It accepts a job configuration (sizeX, sizeY) and a byte stream carrying sizeX samples of X followed by sizeY samples of Y.
- It stores the samples in two internal 32x8 memories and serves them to the processor through asynchronous read ports.
- It issues a one-cycle start, then holds the memories and sizes stable until the processor signals done.

Parameters:
- DATA_WIDTH, 8: sample width.
- ADDR_WIDTH, 5: memory address width; each memory has 2**ADDR_WIDTH entries.

Ports:
- clk  in  1  single clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- cfg_sizeX_i  in  ADDR_WIDTH  X length for next job
- cfg_sizeY_i  in  ADDR_WIDTH  Y length for next job
- cfg_valid_i  in  1  config request; sampled only in IDLE
- s_data_i  in  DATA_WIDTH  stream sample
- s_valid_i  in  1  stream sample valid
- s_ready_o  out  1  loader accepts a sample this cycle
- memXaddr_i  in  ADDR_WIDTH  processor X read address
- dataX_o  out  DATA_WIDTH  memX[memXaddr_i], combinational
- memYaddr_i  in  ADDR_WIDTH  processor Y read address
- dataY_o  out  DATA_WIDTH  memY[memYaddr_i], combinational
- sizeX_o  out  ADDR_WIDTH  latched sizeX to processor
- sizeY_o  out  ADDR_WIDTH  latched sizeY to processor
- start_o  out  1  one-cycle start pulse to processor
- done_i  in  1  processor done pulse
- busy_o  out  1  high whenever state != IDLE
- job_done_o  out  1  one-cycle pulse when a job completes
- err_o  out  1  one-cycle pulse on a rejected config

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, cnt=0, sizeX_o=0, sizeY_o=0.
  - s_ready_o, start_o, busy_o, job_done_o and err_o are all 0.
  - Memory contents are not reset; reads of unwritten entries are don't-care.
  - A reset in any state aborts the job immediately; no start or done pulse follows.
- States:
  - IDLE: s_ready_o=0.
    - cfg_valid_i with both sizes nonzero: latch sizes into sizeX_o/sizeY_o, cnt<=0, go to LOAD_X.
    - cfg_valid_i with either size 0: err_o=1 next cycle, stay in IDLE, sizes unchanged.
  - LOAD_X: s_ready_o=1.
    - Transfer occurs when s_valid_i & s_ready_o: memX[cnt]<=s_data_i, cnt<=cnt+1.
    - On the transfer with cnt==sizeX_o-1: cnt<=0, go to LOAD_Y.
  - LOAD_Y: same as LOAD_X but writes memY. The final transfer (cnt==sizeY_o-1) goes to START.
  - START: s_ready_o=0, start_o=1 for exactly this one cycle, then go to WAIT_DONE.
  - WAIT_DONE: s_ready_o=0.
    - On done_i=1: job_done_o=1 next cycle, go to IDLE.
    - done_i is ignored in every other state.
- Registered outputs:
  - start_o, job_done_o and err_o are registered pulses.
  - s_ready_o and busy_o decode the current state (no combinational path from inputs).
- Stream rules:
  - No sample is lost or duplicated under arbitrary s_valid_i gaps.
  - s_data_i is ignored when s_valid_i=0 or s_ready_o=0.
  - The X-to-Y boundary costs no bubble: the first Y sample can transfer the cycle after the last X sample.
- Latency: from the last Y transfer edge, start_o is high in the next cycle. Minimum job load time is sizeX+sizeY transfer cycles.
- Stability: memX, memY, sizeX_o and sizeY_o do not change from START until return to IDLE. cfg_valid_i outside IDLE is ignored; there is no queueing.
- Read ports are always active. Addresses at or beyond size return the stored (possibly stale) entry; range guarding belongs to the processor.
- Counter: cnt is ADDR_WIDTH bits and never wraps, because sizes are at most 2**ADDR_WIDTH-1.
- Back-to-back jobs: new config is accepted the cycle after return to IDLE. Old memory contents persist and are overwritten by the new load.

Decomposition:
- Shared package holds DATA_WIDTH/ADDR_WIDTH defaults and the state encoding localparams (IDLE, LOAD_X, LOAD_Y, START, WAIT_DONE; 3-bit binary).
- Sub-module conv_input_mem: 2**ADDR_WIDTH x DATA_WIDTH register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port. It is instantiated twice (X, Y).
- The FSM, counter and size registers stay in the top module.

Test Plan:
- Basic job: sizes X=3, Y=2; stream 1,2,3,4,5 with continuous valid. Required: memX=[1,2,3], memY=[4,5], start_o exactly one cycle after the 5th transfer, busy_o=1 throughout. done_i pulse gives job_done_o next cycle and busy_o=0.
- Gapped stream: X=4, Y=4, s_valid_i toggled pseudo-randomly. Required: memories hold exactly the 8 accepted values in order, and s_ready_o=1 only in LOAD states.
- Bad config: cfg_sizeX_i=0, cfg_sizeY_i=5. Required: one-cycle err_o, state stays IDLE, sizeX_o/sizeY_o unchanged, s_ready_o=0.
- Max size: X=31, Y=31 with values 0..61. Required: no counter wrap, dataX_o at address 30 is 30, dataY_o at address 30 is 61, one start_o.
- Ignored inputs: cfg_valid_i and s_valid_i asserted during WAIT_DONE with new data. Required: sizes and memories unchanged, no s_ready_o, no second start.
- Reset mid-load: rstn low after 2 of 3 X samples. Required: all outputs 0 asynchronously, state IDLE, and a subsequent full job completes normally.
